dma_chn_arb: RTL and testbench
==============================

# dma_chn_arb

Channel arbiter and transfer sequencer for the 16-channel DMA master port. It selects one requesting channel using two-level priority with round-robin inside each level. It drives the one-hot channel code and bus-request/transfer-valid strobes that steer the master bus mux. It then sequences one read beat followed by one write beat for the winner before re-arbitrating.

## Interface
- NUM_CHN, 16, channel count; the one-hot vector width. Only 16 is supported.
- hclk  in  1  AHB clock; all state updates on the rising edge.
- hrst_n  in  1  reset, asynchronous, active-low.
- gbc_chnc_dmacen  in  1  global DMA enable; requests are ignored while low.
- chn_req  in  16  per-channel level request for one read+write beat pair.
- chn_prio  in  16  per-channel priority: 1 = high, 0 = low.
- hready  in  1  qualified ready from the bus mux (m_hready & grant_d1 & busreq).
- busy_chn_code  out  16  one-hot selected channel, registered.
- arb_bmux_trgvld  out  1  one-cycle bus-request trigger.
- arb_bmux_transvld  out  1  address-phase valid (NONSEQ request).
- arb_chn_wrphase  out  1  0 = read beat in progress, 1 = write beat; channels present the matching address and hwrite.
- chn_done  out  16  one-hot, one-cycle pulse when the write data phase completes.
- chn_abort  out  16  one-hot, one-cycle pulse when the sequence is abandoned because of a disable.

## Operation
- eff_req = chn_req & {16{gbc_chnc_dmacen}}.
- Winner selection:
  - If any high-priority request is set (eff_req & chn_prio non-zero), pick among those; otherwise pick among the low-priority requests.
  - Each level keeps its own 4-bit round-robin pointer, ptr_hi and ptr_lo. Search starts at ptr+1 and wraps 15→0.
  - On a grant, the pointer of the winning level is set to the winner index. The other level's pointer is unchanged.
- FSM states: IDLE, GRANT, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA.
  - IDLE: if eff_req ≠ 0, latch the winner into busy_chn_code and go to GRANT. Otherwise stay in IDLE.
  - GRANT: arb_bmux_trgvld=1 for this one cycle, then go to RD_ADDR.
  - RD_ADDR: transvld=1, wrphase=0.
    - hready=1 → RD_DATA.
    - dmacen=0 → IDLE, with a chn_abort pulse.
  - RD_DATA: transvld=0, wrphase=0. hready=1 → WR_ADDR.
    - If dmacen=0 at that edge → IDLE, with a chn_abort pulse.
  - WR_ADDR: wrphase=1, transvld=1, and arb_bmux_trgvld=1 on the entry cycle to keep the bus request alive.
    - hready=1 → WR_DATA.
    - dmacen=0 → IDLE, with a chn_abort pulse.
  - WR_DATA: transvld=0, wrphase=1. hready=1 → IDLE, with a chn_done pulse.
- busy_chn_code changes only on the IDLE→GRANT transition and holds in every other state, including IDLE. It is therefore always one-hot, so the mux never sees its X default.
- A channel dropping chn_req mid-sequence does not stop the sequence. Only dmacen aborts.
- chn_done and chn_abort equal busy_chn_code during their pulse cycle and are 0 otherwise.

## Timing
- Reset values:
  - busy_chn_code = 16'h0001.
  - arb_bmux_trgvld = 0, arb_bmux_transvld = 0, arb_chn_wrphase = 0.
  - chn_done = 0, chn_abort = 0.
  - ptr_hi = ptr_lo = 4'hF, so channel 0 wins first.
  - FSM state = IDLE.
- All outputs are registered; none is combinational from an input.
- Request-to-grant latency: chn_req rising in cycle n (while in IDLE) gives busy_chn_code valid and trgvld=1 in cycle n+1, and transvld=1 from cycle n+2.
- Minimum sequence with zero wait states is 6 cycles, IDLE through WR_DATA. The next arbitration is evaluated in the IDLE cycle after chn_done.
- With hready low, each ADDR/DATA state extends cycle-by-cycle; outputs hold.
- Simultaneous events:
  - If dmacen falls in the same cycle that hready completes an ADDR state, the abort wins: the FSM goes to IDLE and the data phase is not tracked.
  - In DATA states the beat always completes; the disable is acted on at that edge.
- Asserting hrst_n mid-sequence returns all state to reset values asynchronously; no done or abort pulse is generated.

## Test plan
- Single channel: chn_req=16'h0010, chn_prio=0, hready=1 → busy_chn_code=16'h0010 one cycle later; trgvld for 1 cycle; transvld high in RD_ADDR and WR_ADDR; chn_done=16'h0010 five cycles after GRANT.
- Round-robin: chn_req=16'h0005 held, all low priority → grant order ch0, ch2, ch0, ch2; each grant separated by a completed chn_done.
- Priority: chn_req=16'h8003, chn_prio=16'h0002 → ch1 wins on every arbitration while it requests. After ch1 drops, ch0 and ch15 alternate.
- Wait states: hready held low 3 cycles in RD_DATA and 2 cycles in WR_ADDR → state, wrphase and busy_chn_code hold; chn_done is delayed exactly 5 cycles.
- Abort: gbc_chnc_dmacen dropped in RD_ADDR for ch3 → chn_abort=16'h0008 for 1 cycle, transvld=0 next cycle, no chn_done. No new grant while disabled.
- Reset mid-WR_DATA → all outputs at reset values immediately. After release with chn_req=16'h0001, ch0 is granted.

Source files
------------

// File: rtl/dma_chn_arb.sv
// dma_chn_arb: two-level round-robin channel arbiter and read/write beat sequencer for the DMA master port
module dma_chn_arb #(
  parameter int NUM_CHN = 16
) (
  input  logic               hclk,
  input  logic               hrst_n,
  input  logic               gbc_chnc_dmacen,
  input  logic [NUM_CHN-1:0] chn_req,
  input  logic [NUM_CHN-1:0] chn_prio,
  input  logic               hready,
  output logic [NUM_CHN-1:0] busy_chn_code,
  output logic               arb_bmux_trgvld,
  output logic               arb_bmux_transvld,
  output logic               arb_chn_wrphase,
  output logic [NUM_CHN-1:0] chn_done,
  output logic [NUM_CHN-1:0] chn_abort
);
  typedef enum logic [2:0] {IDLE, GRANT, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA} state_e;
  state_e             state_q, state_d;
  logic [3:0]         ptr_hi_q, ptr_hi_d, ptr_lo_q, ptr_lo_d, win;
  logic [NUM_CHN-1:0] busy_q, busy_d, done_q, done_d, abort_q, abort_d, eff_req, hi_req;
  logic               trgvld_q, trgvld_d, transvld_q, transvld_d, wrphase_q, wrphase_d, use_hi;
  // First set bit after ptr, wrapping; ptr itself is checked last
  function automatic logic [3:0] rr_pick(input logic [NUM_CHN-1:0] v, input logic [3:0] ptr);
    logic [3:0] idx;
    rr_pick = ptr;
    for (int i = 16; i >= 1; i--) begin
      idx = ptr + 4'(i);
      if (v[idx]) rr_pick = idx;
    end
  endfunction
  // Winner selection: high level preempts low level, each with its own pointer
  always_comb begin
    eff_req = chn_req & {NUM_CHN{gbc_chnc_dmacen}};
    hi_req  = eff_req & chn_prio;
    use_hi  = |hi_req;
    win     = use_hi ? rr_pick(hi_req, ptr_hi_q) : rr_pick(eff_req, ptr_lo_q);
  end
  // Next state, latched winner and pulse generation
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    ptr_hi_d = ptr_hi_q;
    ptr_lo_d = ptr_lo_q;
    done_d   = '0;
    abort_d  = '0;
    case (state_q)
      IDLE: if (|eff_req) begin
        state_d  = GRANT;
        busy_d   = {{(NUM_CHN-1){1'b0}}, 1'b1} << win;
        ptr_hi_d = use_hi ? win : ptr_hi_q;
        ptr_lo_d = use_hi ? ptr_lo_q : win;
      end
      GRANT: state_d = RD_ADDR;
      RD_ADDR: if (!gbc_chnc_dmacen) begin
        state_d = IDLE;
        abort_d = busy_q;
      end else if (hready) state_d = RD_DATA;
      RD_DATA: if (hready) begin
        state_d = gbc_chnc_dmacen ? WR_ADDR : IDLE;
        abort_d = gbc_chnc_dmacen ? '0 : busy_q;
      end
      WR_ADDR: if (!gbc_chnc_dmacen) begin
        state_d = IDLE;
        abort_d = busy_q;
      end else if (hready) state_d = WR_DATA;
      WR_DATA: if (hready) begin
        state_d = IDLE;
        done_d  = busy_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // Strobes are decoded from the next state so they appear registered in the state they describe
  always_comb begin
    trgvld_d   = (state_d == GRANT) || (state_d == WR_ADDR && state_q != WR_ADDR);
    transvld_d = (state_d == RD_ADDR) || (state_d == WR_ADDR);
    wrphase_d  = (state_d == WR_ADDR) || (state_d == WR_DATA);
  end
  // FSM state register
  always_ff @(posedge hclk or negedge hrst_n)
    if (!hrst_n) state_q <= IDLE;
    else state_q <= state_d;
  // Datapath and output registers
  always_ff @(posedge hclk or negedge hrst_n)
    if (!hrst_n) begin
      busy_q     <= {{(NUM_CHN-1){1'b0}}, 1'b1};
      ptr_hi_q   <= 4'hF;
      ptr_lo_q   <= 4'hF;
      done_q     <= '0;
      abort_q    <= '0;
      trgvld_q   <= 1'b0;
      transvld_q <= 1'b0;
      wrphase_q  <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      ptr_hi_q   <= ptr_hi_d;
      ptr_lo_q   <= ptr_lo_d;
      done_q     <= done_d;
      abort_q    <= abort_d;
      trgvld_q   <= trgvld_d;
      transvld_q <= transvld_d;
      wrphase_q  <= wrphase_d;
    end
  assign busy_chn_code     = busy_q;
  assign arb_bmux_trgvld   = trgvld_q;
  assign arb_bmux_transvld = transvld_q;
  assign arb_chn_wrphase   = wrphase_q;
  assign chn_done          = done_q;
  assign chn_abort         = abort_q;
endmodule

// File: tb/tb_dma_chn_arb.sv
// tb_dma_chn_arb: random and directed checks of dma_chn_arb against a sequence-level model
module tb_dma_chn_arb;
  logic        hclk = 0, hrst_n = 1, en = 0, hready = 1;
  logic [15:0] req = 0, prio = 0;
  logic [15:0] busy, done, abort, g;
  logic        trg, tv, wp;
  int          tests = 0, errs = 0;
  int          m_p, m_ph, m_pl;
  logic [15:0] m_code, m_done, m_abort;
  logic        m_first;
  dma_chn_arb dut (
    .hclk(hclk), .hrst_n(hrst_n), .gbc_chnc_dmacen(en), .chn_req(req), .chn_prio(prio),
    .hready(hready), .busy_chn_code(busy), .arb_bmux_trgvld(trg), .arb_bmux_transvld(tv),
    .arb_chn_wrphase(wp), .chn_done(done), .chn_abort(abort)
  );
  always #5 hclk = ~hclk;
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // Round-robin choice: smallest forward distance from the pointer, pointer itself last
  function automatic int pick(input logic [15:0] v, input int ptr);
    int best = -1, bd = 99;
    for (int i = 0; i < 16; i++)
      if (v[i] && ((i - ptr + 15) % 16) < bd) begin
        bd = (i - ptr + 15) % 16;
        best = i;
      end
    return best;
  endfunction
  // Phases: 0 idle, 1 grant, 2 read addr, 3 read data, 4 write addr, 5 write data
  always @(posedge hclk or negedge hrst_n) begin : mdl
    int p, w, ph, pl;
    logic [15:0] code, dn, ab, eff, hi;
    logic first;
    if (!hrst_n) begin
      m_p <= 0; m_code <= 16'h0001; m_ph <= 15; m_pl <= 15;
      m_done <= 0; m_abort <= 0; m_first <= 0;
    end else begin
      p = m_p; code = m_code; ph = m_ph; pl = m_pl; dn = 0; ab = 0; first = 0;
      eff = en ? req : 16'h0;
      hi = eff & prio;
      case (p)
        0: if (eff != 0) begin
          if (hi != 0) begin w = pick(hi, ph); ph = w; end
          else begin w = pick(eff, pl); pl = w; end
          code = 16'h0001 << w;
          p = 1;
        end
        1: p = 2;
        2, 4: if (!en) begin ab = code; p = 0; end else if (hready) p = p + 1;
        3: if (hready) begin
          if (!en) begin ab = code; p = 0; end
          else begin p = 4; first = 1; end
        end
        5: if (hready) begin dn = code; p = 0; end
        default: p = 0;
      endcase
      m_p <= p; m_code <= code; m_ph <= ph; m_pl <= pl;
      m_done <= dn; m_abort <= ab; m_first <= first;
    end
  end
  // Every-cycle comparison against the model
  always @(negedge hclk)
    if (hrst_n) begin
      chk("m_busy", busy, m_code);
      chk("m_trgvld", 16'(trg), 16'(m_p == 1 || (m_p == 4 && m_first)));
      chk("m_transvld", 16'(tv), 16'(m_p == 2 || m_p == 4));
      chk("m_wrphase", 16'(wp), 16'(m_p >= 4));
      chk("m_done", done, m_done);
      chk("m_abort", abort, m_abort);
    end
  task automatic do_reset();
    hrst_n = 0; req = 0; prio = 0; en = 0; hready = 1;
    repeat (2) @(negedge hclk);
    hrst_n = 1;
  endtask
  task automatic next_grant(output logic [15:0] code);
    code = 16'hxxxx;
    for (int i = 0; i < 40; i++) begin
      @(negedge hclk);
      if (trg && !wp) begin
        code = busy;
        return;
      end
    end
    tests++; errs++;
    $display("FAIL grant_timeout: no grant within 40 cycles at %0t", $time);
  endtask
  initial begin
    #1 hrst_n = 0;
    do_reset();
    chk("rst_busy", busy, 16'h0001);
    chk("rst_trg", 16'(trg), 0);
    chk("rst_tv", 16'(tv), 0);
    chk("rst_wp", 16'(wp), 0);
    en = 1;
    req = 16'h0010;
    for (int c = 1; c <= 6; c++) begin
      @(negedge hclk);
      if (c == 1) req = 0;
      chk("single_busy", busy, 16'h0010);
      chk("single_trg", 16'(trg), 16'(c == 1 || c == 4));
      chk("single_tv", 16'(tv), 16'(c == 2 || c == 4));
      chk("single_done", done, c == 6 ? 16'h0010 : 16'h0);
    end
    do_reset();
    en = 1; req = 16'h0005;
    for (int k = 0; k < 4; k++) begin
      next_grant(g);
      chk("rr_grant", g, k % 2 ? 16'h0004 : 16'h0001);
    end
    do_reset();
    en = 1; req = 16'h8003; prio = 16'h0002;
    for (int k = 0; k < 3; k++) begin
      next_grant(g);
      chk("prio_hi", g, 16'h0002);
    end
    req = 16'h8001;
    for (int k = 0; k < 3; k++) begin
      next_grant(g);
      chk("prio_lo", g, k == 1 ? 16'h8000 : 16'h0001);
    end
    do_reset();
    en = 1; req = 16'h0004;
    for (int c = 1; c <= 11; c++) begin
      @(negedge hclk);
      if (c == 1) req = 0;
      chk("ws_busy", busy, 16'h0004);
      chk("ws_trg", 16'(trg), 16'(c == 1 || c == 7));
      chk("ws_tv", 16'(tv), 16'(c == 2 || (c >= 7 && c <= 9)));
      chk("ws_wp", 16'(wp), 16'(c >= 7 && c <= 10));
      chk("ws_done", done, c == 11 ? 16'h0004 : 16'h0);
      hready = (c inside {3, 4, 5, 7, 8}) ? 1'b0 : 1'b1;
    end
    do_reset();
    en = 1; req = 16'h0008;
    for (int c = 1; c <= 8; c++) begin
      @(negedge hclk);
      chk("ab_busy", busy, 16'h0008);
      chk("ab_tv", 16'(tv), 16'(c == 2));
      chk("ab_abort", abort, c == 3 ? 16'h0008 : 16'h0);
      chk("ab_done", done, 0);
      if (c >= 3) chk("ab_nogrant", 16'(trg), 0);
      if (c == 2) en = 0;
    end
    do_reset();
    en = 1; req = 16'h0020;
    for (int c = 1; c <= 5; c++) begin
      @(negedge hclk);
      if (c == 1) req = 0;
    end
    chk("rst_mid_wp", 16'(wp), 1);
    chk("rst_mid_busy", busy, 16'h0020);
    hready = 0;
    #1 hrst_n = 0;
    #1;
    chk("arst_busy", busy, 16'h0001);
    chk("arst_trg", 16'(trg), 0);
    chk("arst_tv", 16'(tv), 0);
    chk("arst_wp", 16'(wp), 0);
    chk("arst_done", done, 0);
    chk("arst_abort", abort, 0);
    @(negedge hclk);
    req = 16'h0001; hready = 1; en = 1; hrst_n = 1;
    @(negedge hclk);
    chk("post_rst_busy", busy, 16'h0001);
    chk("post_rst_trg", 16'(trg), 1);
    req = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      req = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom & $urandom);
      prio = 16'($urandom & $urandom);
      hready = $urandom_range(0, 3) != 0;
      en = $urandom_range(0, 15) != 0;
      @(negedge hclk);
    end
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
endmodule
